// File: rtl/fir_out_buffer_if.sv
// Handshake bundle between the FIR datapath, the output buffer and its consumer.
// Optional peak-tracking port is present only when FIR_OUT_PEAK_EN is defined.
interface fir_out_buffer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             clr;
`ifdef FIR_OUT_PEAK_EN
  logic [WIDTH-1:0] peak;

  // Producer/consumer side (drives samples, ready and clear).
  modport master (
    output in_data, in_valid, out_ready, clr,
    input  out_data, out_valid, count, overflow, peak
  );

  // Buffer side.
  modport slave (
    input  in_data, in_valid, out_ready, clr,
    output out_data, out_valid, count, overflow, peak
  );
`else
  // Producer/consumer side (drives samples, ready and clear).
  modport master (
    output in_data, in_valid, out_ready, clr,
    input  out_data, out_valid, count, overflow
  );

  // Buffer side.
  modport slave (
    input  in_data, in_valid, out_ready, clr,
    output out_data, out_valid, count, overflow
  );
`endif
endinterface

// File: rtl/fir_out_buffer.sv
// FIR output sample buffer: small circular FIFO with show-ahead valid/ready
// output, explicit occupancy count and sticky overflow flag.
// Optional feature macro: FIR_OUT_PEAK_EN (running unsigned peak of accepted samples).
module fir_out_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  fir_out_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             overflow_q;

  logic pop;
  logic push;
  logic drop;

  // Handshake decisions; out_ready only matters here, never on an output path.
  always_comb begin
    pop  = (count_q != '0) && bus.out_ready;
    push = bus.in_valid && ((count_q != FULL) || pop);
    drop = bus.in_valid && !push;
  end

  // Storage, pointers, occupancy and sticky overflow.
  // NOTE: storage is reset explicitly so out_data never exposes stale samples after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.in_data;
        wr_ptr      <= wr_ptr + 1'b1;  // power-of-two depth: wraps naturally
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;

      // A drop in the same cycle as clr keeps the flag set.
      if (drop)         overflow_q <= 1'b1;
      else if (bus.clr) overflow_q <= 1'b0;
    end
  end

  // Show-ahead head of FIFO, masked to zero when empty; driven only by registers.
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = (count_q != '0) ? mem[rd_ptr] : '0;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;

`ifdef FIR_OUT_PEAK_EN
  logic [WIDTH-1:0] peak_q;

  // Running maximum of accepted samples; clr restarts it, a same-cycle push seeds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
    end else if (bus.clr) begin
      peak_q <= push ? bus.in_data : '0;
    end else if (push && (bus.in_data > peak_q)) begin
      peak_q <= bus.in_data;
    end
  end

  assign bus.peak = peak_q;
`endif
endmodule
